// File: rtl/adder_tree_pkg.sv
// ----------------------------------------------------------------------------
// adder_tree_pkg
// Shared widths and types for the four-operand adder tree.
//   OPERAND_W : width of each unsigned operand (8)
//   PAIR_W    : width of a level-1 partial sum (9)
//   SUM_W     : width of the full-precision tree result (10)
// ----------------------------------------------------------------------------
package adder_tree_pkg;

   localparam int OPERAND_W = 8;
   localparam int PAIR_W    = OPERAND_W + 1;
   localparam int SUM_W     = 10;

   typedef logic [OPERAND_W-1:0] operand_t;
   typedef logic [PAIR_W-1:0]    pair_t;
   typedef logic [SUM_W-1:0]     sum_t;

   // True when a full-precision result does not fit in one operand width.
   function automatic logic exceeds_operand(input sum_t value);
      return |value[SUM_W-1:OPERAND_W];
   endfunction

endpackage

// File: rtl/adder_pair.sv
// ----------------------------------------------------------------------------
// adder_pair
// Unsigned N-bit + N-bit adder producing an (N+1)-bit result, so the carry
// out is never lost. Purely combinational.
//   a : input  [N-1:0]  first addend
//   b : input  [N-1:0]  second addend
//   s : output [N:0]    a + b
// ----------------------------------------------------------------------------
module adder_pair
   import adder_tree_pkg::*;
#(
   parameter int N = OPERAND_W
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N:0]   s
);

   // Zero-extend both addends so the addition is carried out at N+1 bits.
   assign s = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_tree4_8.sv
// ----------------------------------------------------------------------------
// adder_tree4_8
// Two-level unsigned adder tree over four 8-bit operands with a combinational
// result and a one-cycle registered copy.
//   clk        : input       rising-edge clock
//   rst        : input       asynchronous active-high reset (registered side only)
//   a, b, c, d : input  [7:0] unsigned operands
//   in_valid   : input       qualifies operands for the registered path
//   sum        : output [7:0] (a+b+c+d) mod 256, combinational
//   sum_wide   : output [9:0] full-precision a+b+c+d, combinational
//   overflow   : output      sum_wide > 255, combinational
//   sum_q      : output [7:0] sum captured on a valid edge
//   overflow_q : output      overflow captured on a valid edge
//   out_valid  : output      sum_q/overflow_q were loaded on the last edge
// ----------------------------------------------------------------------------
module adder_tree4_8
   import adder_tree_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] c,
   input  logic [7:0] d,
   input  logic       in_valid,
   output logic [7:0] sum,
   output logic [9:0] sum_wide,
   output logic       overflow,
   output logic [7:0] sum_q,
   output logic       overflow_q,
   output logic       out_valid
);

   pair_t sum_ab;
   pair_t sum_cd;

   // Level 1: two independent 8-bit pairs.
   adder_pair #(.N(OPERAND_W)) u_pair_ab (
      .a (a),
      .b (b),
      .s (sum_ab)
   );

   adder_pair #(.N(OPERAND_W)) u_pair_cd (
      .a (c),
      .b (d),
      .s (sum_cd)
   );

   // Level 2: combine the 9-bit partial sums into the 10-bit result.
   adder_pair #(.N(PAIR_W)) u_pair_root (
      .a (sum_ab),
      .b (sum_cd),
      .s (sum_wide)
   );

   assign sum      = sum_wide[OPERAND_W-1:0];
   assign overflow = exceeds_operand(sum_wide);

   // Reset clears only the registered copy; the combinational tree keeps
   // tracking the operands regardless of rst.
   // NOTE: non-blocking assignments here so every register samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q      <= '0;
         overflow_q <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum_q      <= sum;
            overflow_q <= overflow;
         end
      end
   end

endmodule

// File: tb/tb_adder_tree4_8.sv
// ----------------------------------------------------------------------------
// tb_adder_tree4_8
// Directed self-checking bench for adder_tree4_8 with hand-computed results.
// ----------------------------------------------------------------------------
module tb_adder_tree4_8;

   logic       clk;
   logic       rst;
   logic [7:0] a, b, c, d;
   logic       in_valid;
   logic [7:0] sum;
   logic [9:0] sum_wide;
   logic       overflow;
   logic [7:0] sum_q;
   logic       overflow_q;
   logic       out_valid;

   int checks   = 0;
   int failures = 0;

   adder_tree4_8 dut (
      .clk        (clk),
      .rst        (rst),
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .in_valid   (in_valid),
      .sum        (sum),
      .sum_wide   (sum_wide),
      .overflow   (overflow),
      .sum_q      (sum_q),
      .overflow_q (overflow_q),
      .out_valid  (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_ops(input logic [7:0] va, vb, vc, vd);
      a = va; b = vb; c = vc; d = vd;
   endtask

   // Registered outputs held at zero while reset is asserted across edges,
   // while the combinational result still follows the operands.
   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      set_ops(8'd10, 8'd20, 8'd30, 8'd40);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sum_q !== 8'd0 || overflow_q !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_regs: got sum_q=%0d ovf_q=%0b vld=%0b expected 0/0/0",
                  sum_q, overflow_q, out_valid);
      end
      checks++;
      if (sum !== 8'd100 || sum_wide !== 10'd100) begin
         failures++;
         $display("FAIL reset_comb: got sum=%0d wide=%0d expected 100/100", sum, sum_wide);
      end
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
   endtask

   // Combinational tree, including wrap and overflow boundaries.
   task automatic test_comb();
      logic [7:0] ta [6] = '{8'd4,   8'd15,  8'd255, 8'd200, 8'd1, 8'd255};
      logic [7:0] tb_[6] = '{8'd5,   8'd3,   8'd255, 8'd56,  8'd2, 8'd0};
      logic [7:0] tc [6] = '{8'd11,  8'd200, 8'd255, 8'd0,   8'd3, 8'd0};
      logic [7:0] td [6] = '{8'd9,   8'd7,   8'd255, 8'd0,   8'd4, 8'd1};
      logic [7:0] es [6] = '{8'd29,  8'd225, 8'd252, 8'd0,   8'd10, 8'd0};
      logic [9:0] ew [6] = '{10'd29, 10'd225, 10'd1020, 10'd256, 10'd10, 10'd256};
      logic       eo [6] = '{1'b0,   1'b0,   1'b1,   1'b1,   1'b0, 1'b1};
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_ops(ta[i], tb_[i], tc[i], td[i]);
         #1;
         checks++;
         if (sum !== es[i] || sum_wide !== ew[i] || overflow !== eo[i]) begin
            failures++;
            $display("FAIL comb_vec%0d: got sum=%0d wide=%0d ovf=%0b expected %0d/%0d/%0b",
                     i, sum, sum_wide, overflow, es[i], ew[i], eo[i]);
         end
      end
   endtask

   // Load on a valid edge, hold on an invalid one, ignore operand changes.
   task automatic test_register();
      @(negedge clk);
      set_ops(8'd4, 8'd5, 8'd11, 8'd9);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (sum_q !== 8'd29 || overflow_q !== 1'b0 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL reg_load: got sum_q=%0d ovf_q=%0b vld=%0b expected 29/0/1",
                  sum_q, overflow_q, out_valid);
      end
      @(negedge clk);
      set_ops(8'd255, 8'd255, 8'd255, 8'd255);
      in_valid = 1'b0;
      #1;
      checks++;
      if (sum_q !== 8'd29 || overflow_q !== 1'b0) begin
         failures++;
         $display("FAIL reg_mid_cycle: got sum_q=%0d ovf_q=%0b expected 29/0", sum_q, overflow_q);
      end
      @(posedge clk);
      #1;
      checks++;
      if (sum_q !== 8'd29 || overflow_q !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reg_hold: got sum_q=%0d ovf_q=%0b vld=%0b expected 29/0/0",
                  sum_q, overflow_q, out_valid);
      end
   endtask

   // Consecutive valid edges each capture their own operands.
   task automatic test_back_to_back();
      @(negedge clk);
      set_ops(8'd255, 8'd255, 8'd255, 8'd255);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (sum_q !== 8'd252 || overflow_q !== 1'b1 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL b2b_first: got sum_q=%0d ovf_q=%0b vld=%0b expected 252/1/1",
                  sum_q, overflow_q, out_valid);
      end
      @(negedge clk);
      set_ops(8'd15, 8'd3, 8'd200, 8'd7);
      @(posedge clk);
      #1;
      checks++;
      if (sum_q !== 8'd225 || overflow_q !== 1'b0 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL b2b_second: got sum_q=%0d ovf_q=%0b vld=%0b expected 225/0/1",
                  sum_q, overflow_q, out_valid);
      end
   endtask

   // Asynchronous reset between edges, then recovery on the next valid edge.
   task automatic test_reset_mid();
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (sum_q !== 8'd0 || overflow_q !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got sum_q=%0d ovf_q=%0b vld=%0b expected 0/0/0",
                  sum_q, overflow_q, out_valid);
      end
      checks++;
      if (sum !== 8'd225 || sum_wide !== 10'd225 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL async_reset_comb: got sum=%0d wide=%0d ovf=%0b expected 225/225/0",
                  sum, sum_wide, overflow);
      end
      rst = 1'b0;
      set_ops(8'd200, 8'd56, 8'd0, 8'd0);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (sum_q !== 8'd0 || overflow_q !== 1'b1 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_load: got sum_q=%0d ovf_q=%0b vld=%0b expected 0/1/1",
                  sum_q, overflow_q, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 1'b0;
      set_ops(8'd0, 8'd0, 8'd0, 8'd0);
      test_reset();
      test_comb();
      test_register();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
